// File: rtl/decmpp_sched.sv
// ---------------------------------------------------------------------------
// decmpp_sched : issues each block's components to the MPP reconstruction
// datapath and keeps the per-component group means used for the midpoints.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decmpp_sched #(
  parameter int BIT_DEPTH = 8,
  parameter int NUM_COMP  = 3,
  parameter int STEP_W    = 3
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      blk_vld_i,
  output logic                      blk_rdy_o,
  input  logic                      blk_first_i,
  input  logic [1:0]                num_comp_i,
  input  logic [NUM_COMP*STEP_W-1:0] step_size_i,
  output logic                      dp_start_o,
  output logic [1:0]                dp_comp_o,
  output logic [STEP_W-1:0]         dp_step_o,
  output logic [4*BIT_DEPTH-1:0]    dp_mp_o,
  input  logic                      dp_done_i,
  input  logic [4*BIT_DEPTH-1:0]    dp_mean_i,
  output logic                      blk_done_o
);

  localparam int                 C_SUM_W    = BIT_DEPTH + STEP_W + 2;
  localparam logic [C_SUM_W-1:0] C_MIDDLE   = C_SUM_W'(1) << (BIT_DEPTH - 1);
  localparam logic [C_SUM_W-1:0] C_MAXVAL   = (C_SUM_W'(1) << BIT_DEPTH) - C_SUM_W'(1);
  localparam logic [1:0]         C_MAX_COMP = 2'(NUM_COMP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             comp_q;
  logic [1:0]             last_q;
  logic                   first_q;
  logic [STEP_W-1:0]      step_q [NUM_COMP];
  logic [BIT_DEPTH-1:0]   mean_q [NUM_COMP][4];
  logic [STEP_W-1:0]      dp_step_q;
  logic [4*BIT_DEPTH-1:0] dp_mp_q;

  logic                   load_issue;
  logic [1:0]             sel_comp;
  logic [STEP_W-1:0]      sel_step;
  logic                   sel_first;
  logic [1:0]             ncomp_last;
  logic [4*BIT_DEPTH-1:0] mp_d;
  logic [BIT_DEPTH-1:0]   mean_g;

  // Twice the rounding bias is simply 1<<step, so the bias itself is never formed.
  function automatic logic [BIT_DEPTH-1:0] calc_mp(input logic [BIT_DEPTH-1:0] mean,
                                                   input logic [STEP_W-1:0]    step);
    logic [C_SUM_W-1:0] bias2;
    logic [C_SUM_W-1:0] hi;
    logic [C_SUM_W-1:0] sum;
    if (step == '0) bias2 = '0;
    else            bias2 = C_SUM_W'(1) << step;
    hi = C_MIDDLE + bias2;
    if (hi > C_MAXVAL) hi = C_MAXVAL;
    sum = C_SUM_W'(mean) + bias2;
    if (sum < C_MIDDLE)  sum = C_MIDDLE;
    else if (sum > hi)   sum = hi;
    return sum[BIT_DEPTH-1:0];
  endfunction

  always_comb begin
    if (num_comp_i == 2'd0)              ncomp_last = 2'd0;
    else if (num_comp_i > C_MAX_COMP)    ncomp_last = C_MAX_COMP - 2'd1;
    else                                 ncomp_last = num_comp_i - 2'd1;
  end

  always_comb begin
    state_d    = state_q;
    load_issue = 1'b0;
    sel_comp   = comp_q;
    sel_step   = step_q[comp_q];
    sel_first  = first_q;
    case (state_q)
      S_IDLE: begin
        if (blk_vld_i) begin
          state_d    = S_ISSUE;
          load_issue = 1'b1;
          sel_comp   = 2'd0;
          sel_step   = step_size_i[STEP_W-1:0];
          sel_first  = blk_first_i;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (dp_done_i) begin
          if (comp_q == last_q) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ISSUE;
            load_issue = 1'b1;
            sel_comp   = comp_q + 2'd1;
            sel_step   = step_q[sel_comp];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Midpoints for whichever component is about to be issued.
  always_comb begin
    mp_d   = '0;
    mean_g = '0;
    for (int g = 0; g < 4; g++) begin
      mean_g = sel_first ? C_MIDDLE[BIT_DEPTH-1:0] : mean_q[sel_comp][g];
      mp_d[g*BIT_DEPTH +: BIT_DEPTH] = calc_mp(mean_g, sel_step);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      comp_q    <= 2'd0;
      last_q    <= 2'd0;
      first_q   <= 1'b0;
      dp_step_q <= '0;
      dp_mp_q   <= '0;
      for (int k = 0; k < NUM_COMP; k++) begin
        step_q[k] <= '0;
        for (int g = 0; g < 4; g++) begin
          mean_q[k][g] <= C_MIDDLE[BIT_DEPTH-1:0];
        end
      end
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && blk_vld_i) begin
        first_q <= blk_first_i;
        last_q  <= ncomp_last;
        for (int k = 0; k < NUM_COMP; k++) begin
          step_q[k] <= step_size_i[k*STEP_W +: STEP_W];
        end
      end
      if (load_issue) begin
        comp_q    <= sel_comp;
        dp_step_q <= sel_step;
        dp_mp_q   <= mp_d;
      end
      // Means are captured even on first-of-slice blocks; only their use is suppressed.
      if (state_q == S_WAIT && dp_done_i) begin
        for (int g = 0; g < 4; g++) begin
          mean_q[comp_q][g] <= dp_mean_i[g*BIT_DEPTH +: BIT_DEPTH];
        end
      end
    end
  end

  assign blk_rdy_o  = (state_q == S_IDLE);
  assign dp_start_o = (state_q == S_ISSUE);
  assign blk_done_o = (state_q == S_DONE);
  assign dp_comp_o  = comp_q;
  assign dp_step_o  = dp_step_q;
  assign dp_mp_o    = dp_mp_q;

endmodule

`default_nettype wire

// File: tb/tb_decmpp_sched.sv
// ---------------------------------------------------------------------------
// tb_decmpp_sched : scoreboard bench for decmpp_sched with a datapath responder.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_decmpp_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        blk_vld = 1'b0;
  logic        blk_first = 1'b0;
  logic [1:0]  num_comp = 2'd0;
  logic [8:0]  step_size = 9'd0;
  logic        dp_done = 1'b0;
  logic [31:0] dp_mean = 32'd0;
  logic        blk_rdy, dp_start, blk_done;
  logic [1:0]  dp_comp;
  logic [2:0]  dp_step;
  logic [31:0] dp_mp;

  decmpp_sched #(.BIT_DEPTH(8), .NUM_COMP(3), .STEP_W(3)) dut (
    .clk_i(clk), .rstn_i(rstn), .blk_vld_i(blk_vld), .blk_rdy_o(blk_rdy),
    .blk_first_i(blk_first), .num_comp_i(num_comp), .step_size_i(step_size),
    .dp_start_o(dp_start), .dp_comp_o(dp_comp), .dp_step_o(dp_step), .dp_mp_o(dp_mp),
    .dp_done_i(dp_done), .dp_mean_i(dp_mean), .blk_done_o(blk_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  comp;
    logic [2:0]  step;
    logic [31:0] mp;
    int          off;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               nm, act, act, expv, expv, cyc);
    end
  endtask

  task automatic push_s(input logic [1:0] c, input logic [2:0] s, input logic [31:0] mp, input int off);
    exp_t e;
    e.comp = c; e.step = s; e.mp = mp; e.off = off;
    exp_q.push_back(e);
  endtask

  // Monitor: pops expectations on every dp_start / blk_done, checks hold stability in WAIT.
  int          acc_cyc = 0;
  int          last_done = -100;
  bit          b2b_arm = 1'b0;
  bit          b2b_pending = 1'b0;
  exp_t        cur;
  int          dexp;

  always @(negedge clk) begin
    if (rstn) begin
      if (blk_vld && blk_rdy) begin
        if (b2b_pending) begin
          check("b2b_accept_cycle", cyc, last_done + 1);
          b2b_pending = 1'b0;
        end
        acc_cyc = cyc;
      end
      if (dp_start) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_start: got dp_comp=%0d, expected no start", dp_comp);
        end else begin
          cur = exp_q.pop_front();
          check("dp_comp", dp_comp, cur.comp);
          check("dp_step", dp_step, cur.step);
          check("dp_mp", dp_mp, cur.mp);
          if (cur.off >= 0) check("start_offset", cyc - acc_cyc, cur.off);
        end
      end else if (!blk_rdy && !blk_done) begin
        check("hold_mp", dp_mp, cur.mp);
        check("hold_comp", dp_comp, cur.comp);
      end
      if (blk_done) begin
        if (done_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got blk_done=1, expected 0");
        end else begin
          dexp = done_q.pop_front();
          check("done_offset", cyc - acc_cyc, dexp);
        end
        last_done = cyc;
        if (b2b_arm) b2b_pending = 1'b1;
      end
    end
  end

  // Datapath responder: raises dp_done resp_dly cycles after each start.
  logic [31:0] resp_mean [3];
  int          resp_dly [3];
  bit          glitch = 1'b0;
  bit          abort = 1'b0;
  int          r_d;
  logic [31:0] r_m;
  bit          r_ab;

  always begin
    @(negedge clk);
    if (dp_start && rstn) begin
      r_d  = resp_dly[dp_comp];
      r_m  = resp_mean[dp_comp];
      r_ab = 1'b0;
      if (glitch) begin
        dp_done = 1'b1;
        dp_mean = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 dp_done = 1'b0;
        r_d = r_d - 1;
      end
      for (int i = 0; i < r_d; i++) begin
        @(posedge clk);
        if (abort) begin
          r_ab = 1'b1;
          break;
        end
      end
      if (!r_ab) begin
        #1 dp_done = 1'b1;
        dp_mean = r_m;
        @(posedge clk);
        #1 dp_done = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blk_rdy"}, blk_rdy, 1);
    check({tag, "_dp_start"}, dp_start, 0);
    check({tag, "_dp_comp"}, dp_comp, 0);
    check({tag, "_dp_step"}, dp_step, 0);
    check({tag, "_dp_mp"}, dp_mp, 0);
    check({tag, "_blk_done"}, blk_done, 0);
  endtask

  task automatic send(input bit first, input logic [1:0] nc, input logic [8:0] steps);
    bit got;
    got = 1'b0;
    blk_first = first; num_comp = nc; step_size = steps; blk_vld = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (blk_done) begin
        got = 1'b1;
        break;
      end
    end
    blk_vld = 1'b0;
    check("blk_done_seen", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit got;
    int ndone;
    resp_dly = '{1, 1, 1};
    resp_mean = '{32'd0, 32'd0, 32'd0};
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk) rstn = 1'b1;
    @(negedge clk);

    // First-of-slice, three components, minimum latency
    resp_mean = '{{8'd200, 8'd128, 8'd130, 8'd100}, {4{8'd128}}, {8'd129, 8'd140, 8'd10, 8'd250}};
    push_s(0, 2, {4{8'd132}}, 1); push_s(1, 2, {4{8'd132}}, 3); push_s(2, 2, {4{8'd132}}, 5);
    done_q.push_back(7);
    send(1'b1, 2'd3, {3'd2, 3'd2, 3'd2});

    // Means from the previous block drive the midpoints
    resp_mean[0] = {8'd90, 8'd80, 8'd70, 8'd60};
    push_s(0, 2, {8'd132, 8'd132, 8'd132, 8'd128}, 1); done_q.push_back(3);
    send(1'b0, 2'd1, {3'd0, 3'd0, 3'd2});

    resp_mean[0] = {4{8'd200}};
    push_s(0, 0, {4{8'd128}}, 1); done_q.push_back(3);
    send(1'b0, 2'd1, {3'd0, 3'd0, 3'd0});

    // num_comp=0 behaves as one component; mean 200 clips to hi=136
    resp_mean[0] = {8'd255, 8'd0, 8'd129, 8'd130};
    push_s(0, 3, {4{8'd136}}, 1); done_q.push_back(3);
    send(1'b0, 2'd0, {3'd0, 3'd0, 3'd3});

    // dp_done while idle must not start anything
    @(posedge clk); #1 dp_done = 1'b1; dp_mean = 32'hFFFF_FFFF;
    @(posedge clk); #1 dp_done = 1'b0;
    @(negedge clk);

    // Per-component step order, slow datapath, dp_done glitch in ISSUE
    glitch = 1'b1;
    resp_dly = '{10, 10, 10};
    resp_mean = '{{8'd255, 8'd120, 8'd140, 8'd100}, {8'd131, 8'd129, 8'd125, 8'd135}, {4{8'd150}}};
    push_s(0, 2, {4{8'd132}}, 1); push_s(1, 1, {4{8'd130}}, 12); push_s(2, 4, {4{8'd144}}, 23);
    done_q.push_back(34);
    send(1'b1, 2'd3, {3'd4, 3'd1, 3'd2});
    glitch = 1'b0;

    resp_dly = '{1, 1, 1};
    resp_mean = '{{4{8'd90}}, {4{8'd50}}, {4{8'd20}}};
    push_s(0, 1, {8'd130, 8'd128, 8'd130, 8'd128}, 1);
    push_s(1, 1, {8'd130, 8'd130, 8'd128, 8'd130}, 3);
    push_s(2, 1, {4{8'd130}}, 5);
    done_q.push_back(7);
    send(1'b0, 2'd3, {3'd1, 3'd1, 3'd1});

    // Reset while waiting on component 1
    resp_dly = '{1, 30, 1};
    resp_mean = '{{4{8'd100}}, {4{8'd0}}, {4{8'd0}}};
    push_s(0, 2, {4{8'd128}}, 1); push_s(1, 2, {4{8'd128}}, 3);
    blk_first = 1'b0; num_comp = 2'd3; step_size = {3'd2, 3'd2, 3'd2}; blk_vld = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dp_start && dp_comp == 2'd1) begin
        got = 1'b1;
        break;
      end
    end
    blk_vld = 1'b0;
    check("comp1_start_seen", got, 1);
    @(posedge clk); #1;
    rstn = 1'b0; abort = 1'b1;
    #1 check_reset_outputs("midrst");
    exp_q.delete(); done_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1; abort = 1'b0;
    @(negedge clk);

    resp_dly = '{1, 1, 1};
    resp_mean[0] = {4{8'd160}};
    push_s(0, 2, {4{8'd132}}, 1); done_q.push_back(3);
    send(1'b0, 2'd1, {3'd2, 3'd2, 3'd2});

    // Back-to-back blocks with blk_vld held high
    resp_mean = '{{4{8'd128}}, {4{8'd10}}, {4{8'd0}}};
    push_s(0, 2, {4{8'd132}}, 1); push_s(1, 2, {4{8'd132}}, 3); done_q.push_back(5);
    push_s(0, 2, {4{8'd132}}, 1); push_s(1, 2, {4{8'd128}}, 3); done_q.push_back(5);
    b2b_arm = 1'b1;
    blk_first = 1'b0; num_comp = 2'd2; step_size = {3'd2, 3'd2, 3'd2}; blk_vld = 1'b1;
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (blk_done) ndone++;
      if (ndone == 2) break;
    end
    blk_vld = 1'b0;
    check("b2b_blocks_done", ndone, 2);

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
